// File: rtl/mont_r2_gen.sv
// Montgomery domain-entry constant generator: C = 2^(2*WIDTH) mod N for an odd N,
// computed by 2*WIDTH serial double-and-reduce steps starting from r = 1.
module mont_r2_gen #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] N,
   output logic [WIDTH-1:0] C,
   output logic             done,
   output logic             busy,
   output logic             err
);

   localparam int            CW        = $clog2(2*WIDTH) + 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(2*WIDTH - 1);

   typedef enum logic [1:0] {IDLE, ITER, ERR} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] n_q;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_d;
   logic [WIDTH-1:0] c_q;
   logic [CW-1:0]    count_q;
   logic             done_q;
   logic             busy_q;
   logic             err_q;
   logic [WIDTH:0]   t;

   // r < n_q holds between steps, so 2*r needs one extra bit and a single
   // conditional subtract brings it back below n_q.
   always_comb begin
      t   = {r_q, 1'b0};
      r_d = t[WIDTH-1:0];
      if (t >= {1'b0, n_q}) begin
         r_d = WIDTH'(t - {1'b0, n_q});
      end
   end

   // NOTE: all state, including the datapath registers, uses non-blocking
   // assignments so every register samples pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         n_q     <= '0;
         r_q     <= '0;
         c_q     <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  n_q     <= N;
                  count_q <= '0;
                  r_q     <= (N == WIDTH'(1)) ? '0 : WIDTH'(1);
                  busy_q  <= 1'b1;
                  state_q <= N[0] ? ITER : ERR;
               end
            end
            ITER: begin
               r_q     <= r_d;
               count_q <= count_q + CW'(1);
               if (count_q == LAST_STEP) begin
                  c_q     <= r_d;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            ERR: begin
               c_q     <= '0;
               done_q  <= 1'b1;
               err_q   <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign C    = c_q;
   assign done = done_q;
   assign busy = busy_q;
   assign err  = err_q;

endmodule

// File: tb/tb_mont_r2_gen.sv
// Self-checking bench for mont_r2_gen: a WIDTH=32 instance for the directed and
// random scenarios and a WIDTH=8 instance swept over every odd modulus.
module tb_mont_r2_gen;

   localparam int W = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] n_in;
   logic [31:0] c_out;
   logic        done, busy, err;
   logic        start8;
   logic [7:0]  n8;
   logic [7:0]  c8;
   logic        done8, busy8, err8;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   mont_r2_gen #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .N(n_in),
      .C(c_out), .done(done), .busy(busy), .err(err)
   );

   mont_r2_gen #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .N(n8),
      .C(c8), .done(done8), .busy(busy8), .err(err8)
   );

   // Reference: 2^(2W) mod N straight from wide-integer arithmetic; even/zero N -> 0.
   function automatic logic [31:0] ref_c(input logic [31:0] n);
      logic [127:0] p;
      if (n[0] == 1'b0) return 32'd0;
      p = 128'd1 << (2*W);
      return 32'(p % {96'd0, n});
   endfunction

   // Starts one run, then observes at each negedge; lat = edges after the accepting edge.
   task automatic run32(input logic [31:0] n, output logic [31:0] c_o, output logic e_o,
                        output int lat, output int bcnt, output bit pulse_ok, output bit tmo);
      @(negedge clk);
      n_in  = n;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_in  = $urandom;
      lat = 0; bcnt = 0; pulse_ok = 1'b1;
      while (done !== 1'b1 && lat < 200) begin
         if (busy === 1'b1) bcnt++;
         if (err !== 1'b0) pulse_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      tmo = (lat >= 200);
      c_o = c_out;
      e_o = err;
      if (busy !== 1'b0) pulse_ok = 1'b0;
      @(negedge clk);
      if (done !== 1'b0 || err !== 1'b0) pulse_ok = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; n_in = 32'd13;
      start8 = 1'b0; n8 = 8'd0;
      repeat (3) @(negedge clk);
      compared++;
      if ({c_out, done, busy, err} !== {32'd0, 3'b000}) begin
         mismatched++;
         $display("FAIL reset_state: C=%h done=%b busy=%b err=%b, want C=0 done=0 busy=0 err=0",
                  c_out, done, busy, err);
      end
      start = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      compared++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_start_dropped: busy=%b done=%b, want 0 0", busy, done);
      end
   endtask

   task automatic test_basic();
      logic [31:0] c; logic e; int lat, bcnt; bit pok, tmo;
      run32(32'hFFFF_FFFB, c, e, lat, bcnt, pok, tmo);
      compared++;
      if (tmo || c !== 32'd25 || e !== 1'b0) begin
         mismatched++;
         $display("FAIL basic_value: C=%h err=%b tmo=%b, want C=00000019 err=0", c, e, tmo);
      end
      compared++;
      if (lat != 64 || bcnt != 64) begin
         mismatched++;
         $display("FAIL basic_latency: lat=%0d busy_cycles=%0d, want 64 64", lat, bcnt);
      end
      compared++;
      if (!pok) begin
         mismatched++;
         $display("FAIL basic_pulse: done/err/busy pulse shape wrong, got 0 want 1");
      end
   endtask

   task automatic test_small();
      logic [31:0] ns [3] = '{32'd13, 32'd3, 32'd1};
      logic [31:0] ws [3] = '{32'd3, 32'd1, 32'd0};
      logic [31:0] c; logic e; int lat, bcnt; bit pok, tmo;
      for (int i = 0; i < 3; i++) begin
         run32(ns[i], c, e, lat, bcnt, pok, tmo);
         compared++;
         if (tmo || c !== ws[i] || e !== 1'b0 || lat != 64 || !pok) begin
            mismatched++;
            $display("FAIL small_n%0d: C=%0d err=%b lat=%0d pulse_ok=%b, want C=%0d err=0 lat=64 pulse_ok=1",
                     ns[i], c, e, lat, pok, ws[i]);
         end
      end
   endtask

   task automatic test_err();
      logic [31:0] ns [2] = '{32'h0000_0010, 32'd0};
      logic [31:0] c; logic e; int lat, bcnt; bit pok, tmo;
      for (int i = 0; i < 2; i++) begin
         run32(32'd13, c, e, lat, bcnt, pok, tmo);   // leave a nonzero C behind
         run32(ns[i], c, e, lat, bcnt, pok, tmo);
         compared++;
         if (tmo || c !== 32'd0 || e !== 1'b1 || lat != 1 || bcnt != 1 || !pok) begin
            mismatched++;
            $display("FAIL err_n%h: C=%0d err=%b lat=%0d busy_cycles=%0d pulse_ok=%b, want 0 1 1 1 1",
                     ns[i], c, e, lat, bcnt, pok);
         end
      end
   endtask

   task automatic test_ignore_start();
      int lat, extra_done, extra_busy;
      logic [31:0] c; logic e;
      @(negedge clk);
      n_in = 32'd13; start = 1'b1;
      @(negedge clk);
      start = 1'b0; n_in = $urandom;
      lat = 0;
      repeat (10) begin @(negedge clk); lat++; end
      start = 1'b1; n_in = 32'd3;
      @(negedge clk); lat++;
      start = 1'b0; n_in = 32'hFFFF_FFF1;
      while (done !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
      c = c_out; e = err;
      compared++;
      if (c !== 32'd3 || e !== 1'b0 || lat != 64) begin
         mismatched++;
         $display("FAIL ignore_result: C=%0d err=%b lat=%0d, want C=3 err=0 lat=64", c, e, lat);
      end
      extra_done = 0; extra_busy = 0;
      repeat (80) begin
         @(negedge clk);
         if (done !== 1'b0) extra_done++;
         if (busy !== 1'b0) extra_busy++;
      end
      compared++;
      if (extra_done != 0 || extra_busy != 0) begin
         mismatched++;
         $display("FAIL ignore_idle: extra_done=%0d extra_busy=%0d, want 0 0", extra_done, extra_busy);
      end
   endtask

   task automatic test_reset_abort();
      int extra_done;
      logic [31:0] c; logic e; int lat, bcnt; bit pok, tmo;
      @(negedge clk);
      n_in = 32'hFFFF_FFFB; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      compared++;
      if ({c_out, done, busy, err} !== {32'd0, 3'b000}) begin
         mismatched++;
         $display("FAIL abort_state: C=%h done=%b busy=%b err=%b, want 0 0 0 0", c_out, done, busy, err);
      end
      reset = 1'b0;
      extra_done = 0;
      repeat (70) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) extra_done++;
      end
      compared++;
      if (extra_done != 0) begin
         mismatched++;
         $display("FAIL abort_silent: active_cycles=%0d, want 0", extra_done);
      end
      run32(32'd13, c, e, lat, bcnt, pok, tmo);
      compared++;
      if (tmo || c !== 32'd3 || e !== 1'b0 || lat != 64) begin
         mismatched++;
         $display("FAIL abort_restart: C=%0d err=%b lat=%0d, want C=3 err=0 lat=64", c, e, lat);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      @(negedge clk);
      n_in = 32'd13; start = 1'b1;
      lat = 0;
      @(negedge clk);
      while (done !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
      compared++;
      if (c_out !== 32'd3 || lat != 64) begin
         mismatched++;
         $display("FAIL b2b_first: C=%0d lat=%0d, want C=3 lat=64", c_out, lat);
      end
      n_in = 32'd3;                       // start still held high
      @(negedge clk);
      compared++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         mismatched++;
         $display("FAIL b2b_retrigger: busy=%b done=%b, want 1 0", busy, done);
      end
      start = 1'b0; n_in = $urandom;
      lat = 0;
      while (done !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
      compared++;
      if (c_out !== 32'd1 || lat != 64) begin
         mismatched++;
         $display("FAIL b2b_second: C=%0d lat=%0d, want C=1 lat=64", c_out, lat);
      end
   endtask

   task automatic test_random();
      logic [31:0] n, c; logic e; int lat, bcnt; bit pok, tmo;
      for (int i = 0; i < 24; i++) begin
         n = $urandom;
         n[0] = ($urandom_range(0, 3) != 0);
         run32(n, c, e, lat, bcnt, pok, tmo);
         compared++;
         if (tmo || c !== ref_c(n) || e !== ~n[0] || lat != (n[0] ? 64 : 1) || !pok) begin
            mismatched++;
            $display("FAIL random_n%h: C=%h err=%b lat=%0d pulse_ok=%b, want C=%h err=%b lat=%0d",
                     n, c, e, lat, pok, ref_c(n), ~n[0], n[0] ? 64 : 1);
         end
      end
   endtask

   task automatic test_exhaustive8();
      int lat;
      logic [16:0] p;
      logic [7:0]  want;
      p = 17'h1_0000;
      for (int n = 1; n < 256; n += 2) begin
         want = 8'(p % 17'(n));
         @(negedge clk);
         n8 = 8'(n); start8 = 1'b1;
         @(negedge clk);
         start8 = 1'b0; n8 = 8'($urandom);
         lat = 0;
         while (done8 !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
         compared++;
         if (c8 !== want || err8 !== 1'b0 || lat != 16) begin
            mismatched++;
            $display("FAIL w8_n%0d: C=%0d err=%b lat=%0d, want C=%0d err=0 lat=16", n, c8, err8, lat, want);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_small();
      test_err();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      test_random();
      test_exhaustive8();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
